// File: rtl/calc_op_sequencer.sv
// Sequenced 16-bit calculator: single-cycle add/sub, 16-cycle shift-add
// multiply and 16-cycle restoring divide with one-cycle result pulse.
module calc_op_sequencer (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic        res_valid,
    output logic [15:0] result,
    output logic [15:0] rem,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] acc;
    logic [4:0]  cnt;

    logic [15:0] mul_acc_nxt;
    logic [16:0] div_t;
    logic [16:0] div_sub;
    logic        div_ge;
    logic [15:0] div_rem_nxt;
    logic [15:0] div_q_nxt;
    logic        last_iter;

    // a_q doubles as multiplicand (MUL) or dividend/quotient shifter (DIV)
    always_comb begin
        mul_acc_nxt = acc + (b_q[0] ? a_q : 16'd0);
        div_t       = {acc, a_q[15]};
        div_sub     = div_t - {1'b0, b_q};
        div_ge      = (div_t >= {1'b0, b_q});
        div_rem_nxt = div_ge ? div_sub[15:0] : div_t[15:0];
        div_q_nxt   = {a_q[14:0], div_ge};
        last_iter   = (cnt == 5'd15);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
            result    <= '0;
            rem       <= '0;
            err       <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            res_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q       <= opa;
                        b_q       <= opb;
                        acc       <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        unique case (op)
                            2'd0: begin
                                state     <= DONE;
                                res_valid <= 1'b1;
                                result    <= opa + opb;
                                rem       <= '0;
                                err       <= 1'b0;
                            end
                            2'd1: begin
                                state     <= DONE;
                                res_valid <= 1'b1;
                                result    <= opa - opb;
                                rem       <= '0;
                                err       <= 1'b0;
                            end
                            2'd2: begin
                                if (opa == '0 || opb == '0) begin
                                    state     <= DONE;
                                    res_valid <= 1'b1;
                                    result    <= '0;
                                    rem       <= '0;
                                    err       <= 1'b0;
                                end else begin
                                    state <= MUL;
                                end
                            end
                            2'd3: begin
                                if (opb == '0) begin
                                    state     <= DONE;
                                    res_valid <= 1'b1;
                                    result    <= 16'hFFFF;
                                    rem       <= opa;
                                    err       <= 1'b1;
                                end else begin
                                    state <= DIV;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                MUL: begin
                    acc <= mul_acc_nxt;
                    a_q <= {a_q[14:0], 1'b0};
                    b_q <= {1'b0, b_q[15:1]};
                    cnt <= cnt + 5'd1;
                    if (last_iter) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        result    <= mul_acc_nxt;
                        rem       <= '0;
                        err       <= 1'b0;
                    end
                end
                DIV: begin
                    acc <= div_rem_nxt;
                    a_q <= div_q_nxt;
                    cnt <= cnt + 5'd1;
                    if (last_iter) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        result    <= div_q_nxt;
                        rem       <= div_rem_nxt;
                        err       <= 1'b0;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer: latency, results, reset abort
// and request handshake.
module tb_calc_op_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic        res_valid;
    logic [15:0] result;
    logic [15:0] rem;
    logic        err;
    logic        busy;

    int total = 0;
    int bad = 0;

    calc_op_sequencer dut (
        .CLK(CLK),
        .RST(RST),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .op(op),
        .opa(opa),
        .opb(opb),
        .res_valid(res_valid),
        .result(result),
        .rem(rem),
        .err(err),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one request, scramble inputs after acceptance, check the result
    task automatic do_op(input string tag, input logic [1:0] o,
                         input logic [15:0] a, input logic [15:0] b,
                         input int lat, input logic [15:0] er,
                         input logic [15:0] erm, input logic ee);
        int n;
        chk({tag, ".ready"}, req_ready, 1);
        op = o;
        opa = a;
        opb = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        op = 2'($urandom);
        opa = 16'($urandom);
        opb = 16'($urandom);
        n = 1;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, ".lat"}, n, lat);
        chk({tag, ".result"}, result, er);
        chk({tag, ".rem"}, rem, erm);
        chk({tag, ".err"}, err, ee);
        tick();
        chk({tag, ".pulse"}, res_valid, 0);
        chk({tag, ".idle"}, req_ready, 1);
        chk({tag, ".hold"}, result, er);
    endtask

    initial begin
        int n;
        int busyc;
        int accepts;
        int pulses;

        RST = 1'b1;
        req_valid = 1'b0;
        op = '0;
        opa = '0;
        opb = '0;
        tick();
        tick();
        chk("rst.result", result, 0);
        chk("rst.rem", rem, 0);
        chk("rst.err", err, 0);
        chk("rst.valid", res_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.ready", req_ready, 1);
        RST = 1'b0;
        tick();

        do_op("add", 2'd0, 16'd1234, 16'd4321, 1, 16'd5555, 16'd0, 1'b0);
        do_op("sub", 2'd1, 16'd3, 16'd5, 1, 16'hFFFE, 16'd0, 1'b0);
        do_op("mul", 2'd2, 16'd300, 16'd300, 17, 16'd24464, 16'd0, 1'b0);
        do_op("mulmax", 2'd2, 16'hFFFF, 16'hFFFF, 17, 16'd1, 16'd0, 1'b0);
        do_op("mulz", 2'd2, 16'd0, 16'd5, 1, 16'd0, 16'd0, 1'b0);
        do_op("div", 2'd3, 16'd1000, 16'd7, 17, 16'd142, 16'd6, 1'b0);
        do_op("div0", 2'd3, 16'd55, 16'd0, 1, 16'hFFFF, 16'd55, 1'b1);
        do_op("divsm", 2'd3, 16'd5, 16'd9, 17, 16'd0, 16'd5, 1'b0);
        do_op("div1", 2'd3, 16'hFFFF, 16'd1, 17, 16'hFFFF, 16'd0, 1'b0);

        // reset during a divide
        op = 2'd3;
        opa = 16'd60000;
        opb = 16'd3;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (8) tick();
        chk("abort.busy", busy, 1);
        RST = 1'b1;
        tick();
        chk("abort.valid", res_valid, 0);
        chk("abort.result", result, 0);
        chk("abort.rem", rem, 0);
        chk("abort.err", err, 0);
        chk("abort.busy0", busy, 0);
        chk("abort.ready", req_ready, 1);
        RST = 1'b0;
        pulses = 0;
        repeat (20) begin
            tick();
            if (res_valid) pulses++;
        end
        chk("abort.pulses", pulses, 0);
        do_op("add2", 2'd0, 16'd2, 16'd2, 1, 16'd4, 16'd0, 1'b0);

        // reset wins over a simultaneous request
        RST = 1'b1;
        req_valid = 1'b1;
        op = 2'd0;
        opa = 16'd9;
        opb = 16'd9;
        tick();
        RST = 1'b0;
        req_valid = 1'b0;
        chk("rstwin.busy", busy, 0);
        tick();
        chk("rstwin.valid", res_valid, 0);
        chk("rstwin.result", result, 0);

        // req_valid held high with changing operands during a multiply
        op = 2'd2;
        opa = 16'd300;
        opb = 16'd300;
        req_valid = 1'b1;
        accepts = 0;
        if (req_ready) accepts++;
        tick();
        n = 1;
        busyc = 0;
        while (!res_valid && n < 40) begin
            if (busy) busyc++;
            if (req_ready) accepts++;
            op = 2'($urandom);
            opa = 16'($urandom);
            opb = 16'($urandom);
            tick();
            n++;
        end
        chk("hs.lat", n, 17);
        chk("hs.result", result, 24464);
        chk("hs.busy", busyc, 16);
        chk("hs.accepts", accepts, 1);
        chk("hs.done_ready", req_ready, 0);
        op = 2'd0;
        opa = 16'd7;
        opb = 16'd8;
        tick();
        chk("hs.ready2", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("hs.valid2", res_valid, 1);
        chk("hs.result2", result, 15);
        tick();
        chk("hs.idle", req_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_op_sequencer.md
CALC_OP_SEQUENCER -- requirements
Module: calc_op_sequencer

Interface
REQ-001 SHALL have the ports below; the block uses one clock, and reset is synchronous and active-high.
REQ-002 CLK  input  1  clock; all state changes on the rising edge.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 req_valid  input  1  operation request present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 op  input  2  operation: 0 add, 1 sub, 2 mul, 3 div.
REQ-007 opa  input  16  left operand (accumulator side), unsigned.
REQ-008 opb  input  16  right operand (entered data), unsigned.
REQ-009 res_valid  output  1  one-cycle pulse; result, rem and err are valid.
REQ-010 result  output  16  sum, difference, product or quotient.
REQ-011 rem  output  16  division remainder; 0 for other operations.
REQ-012 err  output  1  set when a division by zero is detected.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have exactly four states:
- IDLE
- MUL
- DIV
- DONE
REQ-015 req_ready SHALL equal 1 only in IDLE.
REQ-016 Acceptance SHALL occur on an edge where req_valid=1 and req_ready=1; op, opa and opb SHALL be captured into internal registers at that edge, and later input changes SHALL have no effect.
REQ-017 For an accepted add or sub, the FSM SHALL go IDLE->DONE, with the result computed modulo 2^16 (sub wraps, no flag), rem=0, err=0.
REQ-018 For an accepted mul with both operands nonzero, the FSM SHALL go IDLE->MUL:
- 16 shift-add iterations, one per cycle, driven by a 5-bit iteration counter;
- product truncated to the low 16 bits;
- rem=0, err=0.
REQ-019 For an accepted div with opb!=0, the FSM SHALL go IDLE->DIV:
- 16 restoring shift-subtract iterations, one per cycle, MSB first;
- result=floor(opa/opb), rem=opa mod opb, err=0.
REQ-020 For an accepted div with opb=0, the FSM SHALL go IDLE->DONE directly, with result=16'hFFFF, rem=opa, err=1.
REQ-021 For an accepted mul with opa=0 or opb=0, the FSM SHALL go IDLE->DONE directly, with result=0.
REQ-022 MUL and DIV SHALL each transition to DONE at the edge completing the 16th iteration.
REQ-023 DONE SHALL last exactly one cycle, assert res_valid during it, then return to IDLE.
REQ-024 Latency from the acceptance edge to res_valid high SHALL be:
- 1 cycle for add, sub, div-by-zero and zero-operand mul;
- 17 cycles for iterative mul or div.
REQ-025 Back-to-back requests SHALL be accepted no more often than every 2 cycles (accept, DONE, IDLE accept); req_valid held high while not ready SHALL be ignored until IDLE.
REQ-026 result, rem and err SHALL be updated only on entry to DONE and SHALL hold until the next DONE.
REQ-027 No backpressure SHALL exist on the result: res_valid is not acknowledged.
REQ-028 Intermediate MUL and DIV register values SHALL NOT appear on the outputs.

Reset
REQ-029 RST=1 at any edge SHALL force IDLE and clear to 0: result, rem, err, res_valid, busy, the iteration counter and the internal operand registers; req_ready SHALL be 1 in the cycle after reset.
REQ-030 Reset asserted mid-MUL or mid-DIV SHALL abort the operation with no res_valid pulse; the first request after reset deassertion SHALL be processed normally.
REQ-031 If RST and req_valid are both high on the same edge, reset SHALL win and the request SHALL NOT be accepted.

Verification
REQ-032 The bench SHALL cover add: op=0, opa=1234, opb=4321 -> res_valid 1 cycle after accept, result=5555, rem=0, err=0.
REQ-033 The bench SHALL cover sub wrap: op=1, opa=3, opb=5 -> result=16'hFFFE, err=0, 1-cycle latency.
REQ-034 The bench SHALL cover mul truncation: op=2, opa=300, opb=300 -> busy for 16 cycles, res_valid at cycle 17, result=24464 (90000 mod 65536).
REQ-035 The bench SHALL cover div: op=3, opa=1000, opb=7 -> result=142, rem=6, at cycle 17; then opb=0 with opa=55 -> result=16'hFFFF, rem=55, err=1 at cycle 1.
REQ-036 The bench SHALL cover reset mid-op: accept div 60000/3, assert RST at iteration 8 -> no res_valid, outputs 0, req_ready=1 next cycle; then add 2+2 -> result=4.
REQ-037 The bench SHALL cover handshake: req_valid held high with changing operands during a MUL -> exactly one acceptance per IDLE visit, and captured operands unaffected by the changes.
